// File: rtl/obstacle_scroller.sv
// Multi-slot obstacle engine: slots scroll left once per running frame and respawn at
// SPAWN_X after an LFSR-randomised gap; answers a registered per-pixel hit query.
module obstacle_scroller #(
  parameter int          NUM_OBS   = 3,
  parameter int          X_WIDTH   = 10,
  parameter int          VEL_WIDTH = 6,
  parameter int          SPAWN_X   = 640,
  parameter int          OBS_W     = 49,
  parameter int          OBS_Y     = 255,
  parameter int          OBS_H     = 80,
  parameter int          MIN_GAP   = 40,
  parameter int          GAP_BITS  = 5,
  parameter int          INIT_GAP  = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         frame_tick_i,
  input  logic                         run_i,
  input  logic                         clear_i,
  input  logic [VEL_WIDTH-1:0]         velocity_i,
  input  logic [X_WIDTH-1:0]           px_i,
  input  logic [8:0]                   py_i,
  output logic [NUM_OBS*X_WIDTH-1:0]   obs_x_o,
  output logic [NUM_OBS-1:0]           obs_active_o,
  output logic                         obs_hit_o,
  output logic [$clog2(NUM_OBS)-1:0]   obs_hit_idx_o,
  output logic [15:0]                  spawn_count_o
);

  localparam int IDX_W = $clog2(NUM_OBS);
  localparam int Y_END = OBS_Y + OBS_H;

  localparam logic [X_WIDTH-1:0] SPAWN_XV   = SPAWN_X[X_WIDTH-1:0];
  localparam logic [X_WIDTH:0]   OBS_W_X    = OBS_W[X_WIDTH:0];
  localparam logic [9:0]         Y_TOP      = OBS_Y[9:0];
  localparam logic [9:0]         Y_BOT      = Y_END[9:0];
  localparam logic [7:0]         MIN_GAP_V  = MIN_GAP[7:0];
  localparam logic [7:0]         INIT_GAP_V = INIT_GAP[7:0];

  logic [X_WIDTH-1:0] x_q [NUM_OBS];
  logic [X_WIDTH-1:0] x_d [NUM_OBS];
  logic [NUM_OBS-1:0] active_q, active_d;
  logic [7:0]         gap_q, gap_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        spawn_cnt_q, spawn_cnt_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;

  logic [X_WIDTH-1:0] vel_s;
  logic               free_found_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [NUM_OBS-1:0] hit_vec_s;
  logic               y_in_s;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [7:0] gap_reload(input logic [15:0] s);
    return MIN_GAP_V + 8'(s[GAP_BITS-1:0]);
  endfunction

  assign vel_s        = X_WIDTH'(velocity_i);
  assign free_found_s = ~&active_q;

  // Lowest free slot of the pre-tick mask (descending scan leaves the lowest).
  always_comb begin
    free_idx_s = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      free_idx_s = active_q[i] ? free_idx_s : IDX_W'(i);
    end
  end

  // Per-slot pixel test, widened by one bit so x + OBS_W cannot wrap.
  always_comb begin
    y_in_s    = ({1'b0, py_i} >= Y_TOP) && ({1'b0, py_i} < Y_BOT);
    hit_vec_s = '0;
    hit_idx_d = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      hit_vec_s[i] = active_q[i] && y_in_s
                  && ({1'b0, px_i} >= {1'b0, x_q[i]})
                  && ({1'b0, px_i} < ({1'b0, x_q[i]} + OBS_W_X));
    end
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      hit_idx_d = hit_vec_s[i] ? IDX_W'(i) : hit_idx_d;
    end
    hit_d = |hit_vec_s;
  end

  // Frame update: move, gap countdown and spawn, all judged on pre-tick state.
  always_comb begin
    x_d         = x_q;
    active_d    = active_q;
    gap_d       = gap_q;
    spawn_cnt_d = spawn_cnt_q;
    lfsr_d      = frame_tick_i ? lfsr_step(lfsr_q) : lfsr_q;
    if (frame_tick_i && run_i) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (active_q[i] && (x_q[i] <= vel_s)) begin
          active_d[i] = 1'b0;
          x_d[i]      = '0;
        end else if (active_q[i]) begin
          x_d[i] = x_q[i] - vel_s;
        end else begin
          x_d[i] = x_q[i];
        end
      end
      // The spawn slot was free before the tick, so the move loop never touched it.
      if (gap_q != 8'd0) begin
        gap_d = gap_q - 8'd1;
      end else if (free_found_s) begin
        x_d[free_idx_s]      = SPAWN_XV;
        active_d[free_idx_s] = 1'b1;
        gap_d                = gap_reload(lfsr_q);
        spawn_cnt_d          = spawn_cnt_q + 16'd1;
      end else begin
        gap_d = 8'd0;
      end
    end else begin
      gap_d = gap_q;
    end
  end

  // State registers: reset restores everything, clear keeps the LFSR and spawn count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i] <= '0;
      end
      active_q    <= '0;
      gap_q       <= INIT_GAP_V;
      lfsr_q      <= LFSR_SEED;
      spawn_cnt_q <= 16'd0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i] <= '0;
      end
      active_q  <= '0;
      gap_q     <= INIT_GAP_V;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      x_q         <= x_d;
      active_q    <= active_d;
      gap_q       <= gap_d;
      lfsr_q      <= lfsr_d;
      spawn_cnt_q <= spawn_cnt_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
    assign obs_x_o[g*X_WIDTH +: X_WIDTH] = x_q[g];
  end

  assign obs_active_o  = active_q;
  assign obs_hit_o     = hit_q;
  assign obs_hit_idx_o = hit_idx_q;
  assign spawn_count_o = spawn_cnt_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: stimulus queues expected values, a negedge
// monitor pops and compares them on the cycle they are due.
module tb_obstacle_scroller;

  logic        clk = 1'b0;
  logic        reset, frame_tick, run, clear;
  logic [5:0]  velocity;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [29:0] obs_x;
  logic [2:0]  obs_active;
  logic        obs_hit;
  logic [1:0]  obs_hit_idx;
  logic [15:0] spawn_count;

  obstacle_scroller dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .run_i        (run),
    .clear_i      (clear),
    .velocity_i   (velocity),
    .px_i         (px),
    .py_i         (py),
    .obs_x_o      (obs_x),
    .obs_active_o (obs_active),
    .obs_hit_o    (obs_hit),
    .obs_hit_idx_o(obs_hit_idx),
    .spawn_count_o(spawn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_X0, F_X1, F_X2, F_ACT, F_HIT, F_IDX, F_CNT} field_e;
  typedef struct {
    string  name;
    int     due;
    field_e f;
    int     exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   finishing = 1'b0;
  int   nt = 0;

  function automatic int actual(input field_e f);
    case (f)
      F_X0:    return int'(obs_x[9:0]);
      F_X1:    return int'(obs_x[19:10]);
      F_X2:    return int'(obs_x[29:20]);
      F_ACT:   return int'(obs_active);
      F_HIT:   return int'(obs_hit);
      F_IDX:   return int'(obs_hit_idx);
      F_CNT:   return int'(spawn_count);
      default: return -1;
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      int   a;
      e = sb.pop_front();
      a = actual(e.f);
      total++;
      if (a != e.exp) begin
        bad++;
        $display("FAIL %s: got %0d, want %0d (cycle %0d)", e.name, a, e.exp, cyc);
      end
    end
    if (finishing && sb.size() > 0) begin
      total += sb.size();
      bad   += sb.size();
      $display("FAIL scoreboard: %0d expectations never reached", sb.size());
      sb.delete();
    end
  end

  // Reference LFSR: x^16+x^14+x^13+x^11+1 from 16'hACE1, n shifts.
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] l;
    logic        b;
    l = 16'hACE1;
    for (int k = 0; k < n; k++) begin
      b = l[0] ^ l[2] ^ l[3] ^ l[5];
      l = {b, l[15:1]};
    end
    return l;
  endfunction

  function automatic int gap_after(input int n);
    logic [15:0] l;
    l = lfsr_after(n);
    return 40 + int'(l[4:0]);
  endfunction

  task automatic push(input string name, input field_e f, input int v, input int lat);
    exp_t e;
    e.name = name;
    e.due  = cyc + lat;
    e.f    = f;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Negative value = field not checked.
  task automatic expect_state(input string name, input int x0, input int x1, input int x2,
                              input int act, input int cnt);
    if (x0 >= 0)  push({name, "_x0"}, F_X0, x0, 0);
    if (x1 >= 0)  push({name, "_x1"}, F_X1, x1, 0);
    if (x2 >= 0)  push({name, "_x2"}, F_X2, x2, 0);
    if (act >= 0) push({name, "_act"}, F_ACT, act, 0);
    if (cnt >= 0) push({name, "_cnt"}, F_CNT, cnt, 0);
  endtask

  task automatic tick(input logic [5:0] v);
    repeat (9) @(posedge clk);
    #1;
    velocity   = v;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    nt++;
  endtask

  task automatic query(input string name, input int x, input int y, input int h, input int idx);
    px = 10'(x);
    py = 9'(y);
    push({name, "_hit"}, F_HIT, h, 1);
    push({name, "_idx"}, F_IDX, idx, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g1, g2, g3, g4, d, n, qv, r, p1, rem;
    reset = 1'b1; frame_tick = 1'b0; run = 1'b0; clear = 1'b0;
    velocity = 6'd0; px = 10'd0; py = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    expect_state("reset", 0, 0, 0, 0, 0);
    push("reset_hit", F_HIT, 0, 0);
    push("reset_idx", F_IDX, 0, 0);
    reset = 1'b0;
    run   = 1'b1;

    // First spawn after the 20-frame initial gap.
    for (int k = 0; k < 20; k++) tick(6'd4);
    expect_state("no_spawn_yet", -1, -1, -1, 0, 0);
    g1 = gap_after(nt);
    tick(6'd4);
    expect_state("first_spawn", 640, -1, -1, 1, 1);
    tick(6'd4);
    expect_state("first_move", 636, -1, -1, 1, 1);

    // Second spawn exactly g1+1 frames after the first.
    for (int k = 0; k < g1 - 1; k++) tick(6'd4);
    expect_state("gap_running", -1, -1, -1, 1, 1);
    g2 = gap_after(nt);
    tick(6'd4);
    expect_state("second_spawn", 640 - 4 * (g1 + 1), 640, -1, 3, 2);

    // Steer slot 0 to x=8 just as the next spawn comes due.
    d  = 640 - 4 * (g1 + 1) - 8;
    n  = g2 - 1;
    qv = d / n;
    r  = d % n;
    for (int k = 0; k < n; k++) tick(6'((k < r) ? qv + 1 : qv));
    expect_state("x_at_8", 8, 640 - d, -1, 3, 2);
    tick(6'd4);
    expect_state("x_at_4", 4, 640 - d - 4, -1, 3, 2);
    g3 = gap_after(nt);
    tick(6'd4);
    expect_state("freed_not_reused", 0, 640 - d - 8, 640, 6, 3);
    p1 = 640 - d - 8;

    // Fill slot 0, then let the gap expire with every slot busy.
    for (int k = 0; k < g3; k++) tick(6'd0);
    expect_state("wait_slot0", 0, p1, 640, 6, 3);
    g4 = gap_after(nt);
    tick(6'd0);
    expect_state("third_fill", 640, p1, 640, 7, 4);
    for (int k = 0; k < g4 + 3; k++) tick(6'd0);
    expect_state("all_busy_hold", 640, p1, 640, 7, 4);
    rem = p1;
    while (rem > 63) begin
      tick(6'd63);
      rem -= 63;
    end
    tick(6'(rem));
    expect_state("slot1_freed", 640 - p1, 0, 640 - p1, 5, 4);
    tick(6'd0);
    expect_state("retry_spawn", 640 - p1, 640, 640 - p1, 7, 5);

    query("idx_lowest", 640 - p1, 300, 1, 0);
    query("idx_slot1", 688, 300, 1, 1);
    query("slot1_right", 689, 300, 0, 0);
    query("slot1_left", 639, 300, 0, 0);

    // Frozen frames, then clear.
    run = 1'b0;
    for (int k = 0; k < 5; k++) tick(6'd10);
    expect_state("frozen", 640 - p1, 640, 640 - p1, 7, 5);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    expect_state("clear", 0, 0, 0, 0, 5);

    // Gap counter must hold while run is low.
    run = 1'b1;
    for (int k = 0; k < 10; k++) tick(6'd4);
    run = 1'b0;
    for (int k = 0; k < 5; k++) tick(6'd4);
    run = 1'b1;
    for (int k = 0; k < 10; k++) tick(6'd4);
    expect_state("gap_frozen_hold", -1, -1, -1, 0, 5);
    tick(6'd4);
    expect_state("spawn_after_clear", 640, 0, 0, 1, 6);
    tick(6'd40);
    expect_state("x600", 600, -1, -1, 1, 6);
    run = 1'b0;

    query("hit_corner", 600, 255, 1, 0);
    query("hit_far_corner", 648, 334, 1, 0);
    query("miss_right", 649, 255, 0, 0);
    query("miss_below", 600, 335, 0, 0);
    query("miss_left", 599, 300, 0, 0);
    query("miss_above", 600, 254, 0, 0);
    px = 10'd600;
    py = 9'd255;

    // Reset landing on a frame tick while the pixel query is hitting.
    reset = 1'b1; frame_tick = 1'b1; run = 1'b1; velocity = 6'd4;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    expect_state("reset_mid", 0, 0, 0, 0, 0);
    push("reset_mid_hit", F_HIT, 0, 0);
    push("reset_mid_idx", F_IDX, 0, 0);
    reset = 1'b0;
    nt = 0;
    px = 10'd0;
    py = 9'd0;

    // Same spawn timing as the first run proves the LFSR went back to its seed.
    for (int k = 0; k < 20; k++) tick(6'd4);
    expect_state("reseed_wait", -1, -1, -1, 0, 0);
    g1 = gap_after(nt);
    tick(6'd4);
    expect_state("reseed_spawn", 640, -1, -1, 1, 1);
    for (int k = 0; k < g1; k++) tick(6'd4);
    expect_state("reseed_hold", -1, -1, -1, 1, 1);
    tick(6'd4);
    expect_state("reseed_second", -1, 640, -1, 3, 2);

    repeat (3) @(posedge clk);
    finishing = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
